pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Instruction-fetch front end; sits directly upstream of the instruction memory.
- Holds the program counter and drives it onto the memory address input.
- Sequences the PC: +4 advance, stall, and branch/jump redirect.
- Raises a sticky trap on a misaligned or out-of-range fetch address; a downstream ready signal paces fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned).
IMEM_WORDS, 1024, instruction memory depth in 32-bit words; legal byte addresses are 0 to IMEM_WORDS*4-4.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
ready_i  input  1  downstream accepts the instruction at pc_o this cycle.
redirect_i  input  1  taken branch/jump; load redirect_target_i.
redirect_target_i  input  32  byte address of redirect target.
pc_o  output  32  current PC; drives instruction memory address A.
pc_plus4_o  output  32  pc_o + 4 (combinational, for link/next-PC use).
valid_o  output  1  pc_o is a legal fetch address and the fetched instruction is valid.
trap_o  output  1  sticky fetch-fault flag.
trap_pc_o  output  32  offending address that caused the trap.
fetch_count_o  output  32  number of accepted fetches.

Behaviour:
- Reset (async, immediate): state=BOOT, pc_o=RESET_PC, valid_o=0, trap_o=0, trap_pc_o=0, fetch_count_o=0. Reset has priority over everything, in any state, mid-cycle.
- An address is illegal if bits[1:0]!=0 or addr[31:2] >= IMEM_WORDS.
- States:
  - BOOT: valid_o=0. Moves to RUN at the next rising edge unconditionally. ready_i and redirect_i are ignored.
  - RUN: valid_o=1, trap_o=0. Next-PC selection is evaluated at each edge, first match wins:
    1. redirect_i=1: if redirect_target_i is illegal, go to TRAP, trap_pc_o<=target, pc_o held. Otherwise pc_o<=redirect_target_i. Redirect takes effect regardless of ready_i.
    2. ready_i=1: candidate=pc_o+4 (32-bit, wraps mod 2^32). If the candidate is illegal, go to TRAP with trap_pc_o<=candidate and pc_o held. Otherwise pc_o<=candidate.
    3. Otherwise: hold pc_o (stall).
  - fetch_count_o increments by 1 on every RUN edge with ready_i=1, including cycles with a simultaneous redirect or a trapping advance. The counter wraps at 2^32.
  - TRAP: valid_o=0, trap_o=1. pc_o, trap_pc_o and fetch_count_o are frozen. ready_i and redirect_i are ignored. TRAP is exited only by rst.
- Latency: a redirect or advance is visible on pc_o one cycle after the sampling edge. pc_plus4_o tracks pc_o with zero latency.
- All state is registered. valid_o and trap_o are decoded from state only, so they are glitch-free.
- A RESET_PC that is itself illegal is a configuration error; the block is not required to detect it.

Test Plan:
- Reset release with ready_i=1: first edge gives BOOT->RUN, pc_o=0x0, valid_o=1, count=0. The next two edges give pc_o=0x4 then 0x8, count=2. pc_plus4_o=0xC.
- At pc_o=0x8, ready_i=0 for 5 cycles -> pc_o stays 0x8, count stays 2, valid_o stays 1.
- redirect_i=1, target=0x40, ready_i=0 -> pc_o=0x40, count unchanged. Repeating with ready_i=1 and target=0x80 -> pc_o=0x80, count+1.
- redirect_i=1, target=0x42 -> trap_o=1, trap_pc_o=0x42, valid_o=0, pc_o held. Subsequent ready_i and redirects have no effect for 10 cycles.
- Redirect to 0xFFC, then ready_i=1 -> trap_o=1, trap_pc_o=0x1000, pc_o=0xFFC, count incremented. A separate run with target 0x1000 also traps.
- Assert rst between clock edges while in TRAP -> all outputs take reset values immediately, without waiting for a clock edge. After release, BOOT then RUN from 0x0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the program counter, sequences +4 / stall / redirect,
// and latches a sticky trap when a fetch address falls outside the instruction memory.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic        trap_o,
    output logic [31:0] trap_pc_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2
    } state_t;

    localparam logic [31:0] LP_WORDS = 32'(IMEM_WORDS);

    // Word index is compared zero-extended so every 30-bit index is range-checked.
    function automatic logic f_illegal(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= LP_WORDS);
    endfunction

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_trap_pc;
    logic [31:0] r_count;
    logic        r_valid;
    logic        r_trap;

    logic [31:0] w_pc_plus4;
    logic        w_redirect_bad;
    logic        w_advance_bad;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_redirect_bad = f_illegal(redirect_target_i);
    assign w_advance_bad  = f_illegal(w_pc_plus4);

    // valid/trap are kept as dedicated flops updated alongside the state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_trap_pc <= 32'd0;
            r_count   <= 32'd0;
            r_valid   <= 1'b0;
            r_trap    <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                    r_valid <= 1'b1;
                end
                S_RUN: begin
                    if (ready_i) begin
                        r_count <= r_count + 32'd1;
                    end
                    if (redirect_i) begin
                        if (w_redirect_bad) begin
                            r_state   <= S_TRAP;
                            r_trap_pc <= redirect_target_i;
                            r_valid   <= 1'b0;
                            r_trap    <= 1'b1;
                        end else begin
                            r_pc <= redirect_target_i;
                        end
                    end else if (ready_i) begin
                        if (w_advance_bad) begin
                            r_state   <= S_TRAP;
                            r_trap_pc <= w_pc_plus4;
                            r_valid   <= 1'b0;
                            r_trap    <= 1'b1;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
                S_TRAP: begin
                    // Frozen until reset.
                    r_valid <= 1'b0;
                    r_trap  <= 1'b1;
                end
                default: begin
                    r_state <= S_BOOT;
                    r_valid <= 1'b0;
                    r_trap  <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o          = r_pc;
    assign pc_plus4_o    = w_pc_plus4;
    assign valid_o       = r_valid;
    assign trap_o        = r_trap;
    assign trap_pc_o     = r_trap_pc;
    assign fetch_count_o = r_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected output snapshots are queued as each step is
// driven and popped for comparison one time unit after the clock edge that should produce them.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        ready_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        trap_o;
    logic [31:0] trap_pc_o;
    logic [31:0] fetch_count_o;

    pc_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(1024)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ready_i          (ready_i),
        .redirect_i       (redirect_i),
        .redirect_target_i(redirect_target_i),
        .pc_o             (pc_o),
        .pc_plus4_o       (pc_plus4_o),
        .valid_o          (valid_o),
        .trap_o           (trap_o),
        .trap_pc_o        (trap_pc_o),
        .fetch_count_o    (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        valid;
        logic        trap;
        logic [31:0] tpc;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   step_id = 0;

    task automatic cmp(input string name, input int id, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL step%0d/%s observed=0x%08h expected=0x%08h", id, name, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic valid, input logic trap,
                            input logic [31:0] tpc, input logic [31:0] cnt);
        exp_t e;
        step_id++;
        e.id = step_id; e.pc = pc; e.valid = valid; e.trap = trap; e.tpc = tpc; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_total++;
        assert (q.size() > 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", q.size());
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("pc",       e.id, pc_o,                e.pc);
            cmp("pc_plus4", e.id, pc_plus4_o,          e.pc + 32'd4);
            cmp("valid",    e.id, {31'd0, valid_o},    {31'd0, e.valid});
            cmp("trap",     e.id, {31'd0, trap_o},     {31'd0, e.trap});
            cmp("trap_pc",  e.id, trap_pc_o,           e.tpc);
            cmp("count",    e.id, fetch_count_o,       e.cnt);
        end
    endtask

    // Drive one cycle of inputs, queue what the following edge must produce, then check it.
    task automatic step(input logic rdy, input logic rd, input logic [31:0] tgt,
                        input logic [31:0] pc, input logic valid, input logic trap,
                        input logic [31:0] tpc, input logic [31:0] cnt);
        ready_i = rdy;
        redirect_i = rd;
        redirect_target_i = tgt;
        push_exp(pc, valid, trap, tpc, cnt);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        // Checked before any clock edge sees rst: the reset must act asynchronously.
        push_exp(32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        pop_check();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        pop_check();
    endtask

    initial begin
        rst = 1'b1;
        ready_i = 1'b0;
        redirect_i = 1'b0;
        redirect_target_i = 32'h0;
        #1;
        push_exp(32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        pop_check();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Boot then sequential advance
        step(1'b1, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0, 32'd0);
        step(1'b1, 1'b0, 32'h0,   32'h4, 1'b1, 1'b0, 32'h0, 32'd1);
        step(1'b1, 1'b0, 32'h0,   32'h8, 1'b1, 1'b0, 32'h0, 32'd2);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 32'h0, 32'h8, 1'b1, 1'b0, 32'h0, 32'd2);

        // Redirects with and without ready
        step(1'b0, 1'b1, 32'h40,  32'h40, 1'b1, 1'b0, 32'h0, 32'd2);
        step(1'b1, 1'b1, 32'h80,  32'h80, 1'b1, 1'b0, 32'h0, 32'd3);
        step(1'b1, 1'b0, 32'h0,   32'h84, 1'b1, 1'b0, 32'h0, 32'd4);

        // Last legal word, then an advance past the end of memory
        step(1'b0, 1'b1, 32'hFFC, 32'hFFC, 1'b1, 1'b0, 32'h0,    32'd4);
        step(1'b1, 1'b0, 32'h0,   32'hFFC, 1'b0, 1'b1, 32'h1000, 32'd5);
        for (int i = 0; i < 10; i++)
            step(1'b1, i[0], 32'h40, 32'hFFC, 1'b0, 1'b1, 32'h1000, 32'd5);

        // Async reset out of TRAP, then redirect exactly to the first out-of-range address
        do_reset();
        step(1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b0, 32'h0,    32'd0);
        step(1'b0, 1'b1, 32'h1000, 32'h0, 1'b0, 1'b1, 32'h1000, 32'd0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 32'h8, 32'h0, 1'b0, 1'b1, 32'h1000, 32'd0);

        // Misaligned redirect while ready is also high: the trapping edge still counts
        do_reset();
        step(1'b1, 1'b1, 32'h42,  32'h0, 1'b1, 1'b0, 32'h0,  32'd0);
        step(1'b1, 1'b0, 32'h0,   32'h4, 1'b1, 1'b0, 32'h0,  32'd1);
        step(1'b1, 1'b1, 32'h42,  32'h4, 1'b0, 1'b1, 32'h42, 32'd2);
        for (int i = 0; i < 10; i++)
            step(i[0], ~i[0], 32'h100, 32'h4, 1'b0, 1'b1, 32'h42, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
